timer_multi: RTL and testbench
==============================

# timer_multi

Multi-channel programmable timer peripheral for the monocycle CPU, and the parametrised successor of the single-channel `timer`. It provides NCH independent down-counters, each programmed through a small write port that the CPU drives from its output ports. Each channel runs in one-shot or periodic mode and drives one interrupt line into the CPU's `pInt` inputs. Each interrupt line is sticky until acknowledged, and a per-channel overrun flag reports a missed acknowledge.

## Interface
Parameters:
- NCH, 4: number of timer channels (1..8).
- WIDTH, 8: counter, period and write-data width (>= 4).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  register write strobe, sampled on the rising edge of clk.
- wr_ch  in  3  target channel; values >= NCH are ignored (no state change).
- wr_reg  in  1  0 = PERIOD register, 1 = CTRL register.
- wr_data  in  WIDTH  write data.
- int_ack  in  NCH  per-channel acknowledge; clears pint[i] and ovr[i].
- pint  out  NCH  per-channel interrupt request, level, sticky.
- ovr  out  NCH  per-channel overrun flag, sticky.
- count  out  NCH*WIDTH  live counter values; channel i at [i*WIDTH +: WIDTH].

## Operation
- Per-channel state: PERIOD (WIDTH bits), CTRL.en, CTRL.per, counter (WIDTH bits), prescale counter (6 bits, only with the macro), pint, ovr.
- CTRL bit mapping:
  - wr_data[0] = en.
  - wr_data[1] = per (1 = periodic, 0 = one-shot).
  - wr_data[3:2] = prescale select (see Configuration).
  - Remaining bits are ignored.
- Channel states: IDLE (en=0) and RUN (en=1).
- CTRL write with en=1, from either state:
  - counter <= PERIOD.
  - prescale counter <= 0.
  - Channel enters RUN; an already running channel restarts.
- CTRL write with en=0: channel enters IDLE; counter holds its value; pint and ovr are unchanged.
- PERIOD write: updates PERIOD only. A running counter is not disturbed; the new value applies at the next reload or start.
- Each tick in RUN:
  - counter != 0: counter decrements by 1.
  - counter == 0: this is an event.
- On an event:
  - pint[i] <= 1.
  - If pint[i] was already 1, ovr[i] <= 1.
  - Periodic: counter <= PERIOD and the channel stays in RUN.
  - One-shot: en <= 0 (IDLE) and counter stays 0.
- Event interval is PERIOD+1 ticks. PERIOD=0 gives an event every tick.
- Counter arithmetic is unsigned and never wraps, because a counter at 0 reloads or stops instead of decrementing.
- int_ack[i]=1 clears pint[i] and ovr[i] on the next edge.
- Ack and an event on the same edge: the event wins, so pint=1. ovr is set only if pint was 1 before that edge.
- Channels are fully independent; simultaneous events on several channels all register.

## Timing
- Reset values while reset=0, applied immediately and asynchronously:
  - PERIOD=0, CTRL=0, counters=0, prescale counters=0.
  - pint=0, ovr=0, count=0.
  - Channels stay IDLE after reset is released.
- Reset asserted mid-count aborts immediately. No event is produced and the state is as after reset.
- Register writes take effect at the sampling edge (E0). With no prescale, count=PERIOD is visible after E0, and the first tick occurs at E1.
- Without prescale: counter reaches 0 after edge E_P and pint rises after edge E_(P+1). Latency from the enabling write edge to pint is PERIOD+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro TIMER_PRESCALER_EN.
- Defined:
  - CTRL[3:2] selects a tick divider: 00 = /1, 01 = /4, 10 = /16, 11 = /64.
  - The per-channel prescale counter increments every cycle in RUN and wraps at divide-1.
  - A tick occurs on the cycle the prescale counter equals divide-1.
  - Event latency from start is (PERIOD+1)*divide cycles.
- Not defined:
  - CTRL[3:2] is ignored and no prescale counters exist.
  - Every cycle in RUN is a tick.

## Test plan
- Reset, then with NCH=4 and WIDTH=8: write PERIOD ch0=5 and CTRL ch0=0x03 -> pint[0] rises 6 cycles after the CTRL write edge and again every 6 cycles; count[7:0] runs 5,4,3,2,1,0,5.
- One-shot: PERIOD ch1=3, CTRL ch1=0x01 -> a single pint[1] pulse-latch after 4 cycles; count[15:8] stays 0; no further events within 20 cycles.
- Overrun and ack: ch2 periodic with PERIOD=1 and no ack -> pint[2]=1 after 2 cycles and ovr[2]=1 after 4 cycles. Then ack coincident with an event -> pint[2] stays 1, and ovr[2] follows the prior value of pint.
- Mid-run writes: ch3 periodic with PERIOD=10; write PERIOD=2 at count=7 -> the current interval completes unchanged and the next intervals are 3 cycles. Write CTRL=0x00 -> counter freezes with pint unchanged. Pulse reset low mid-count -> all outputs 0 immediately.
- With TIMER_PRESCALER_EN: ch0 with PERIOD=2 and CTRL=0x07 (/4, periodic) -> pint[0] after 12 cycles; a write to wr_ch=5 -> no state change on any channel.

Source files
------------

// File: rtl/timer_multi.sv
`default_nettype none
// timer_multi: NCH independent down-counter timers with sticky interrupt and overrun flags. Rev 1.0
// Optional macro TIMER_PRESCALER_EN adds a per-channel /1,/4,/16,/64 tick divider (CTRL[3:2]).
module timer_multi #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [2:0]           wr_ch,
    input  logic                 wr_reg,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [NCH-1:0]       int_ack,
    output logic [NCH-1:0]       pint,
    output logic [NCH-1:0]       ovr,
    output logic [NCH*WIDTH-1:0] count
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state     [NCH];
    state_t           state_nx  [NCH];
    logic [WIDTH-1:0] period    [NCH];
    logic [WIDTH-1:0] period_nx [NCH];
    logic [WIDTH-1:0] cnt       [NCH];
    logic [WIDTH-1:0] cnt_nx    [NCH];
    logic [NCH-1:0]   per, per_nx, pint_nx, ovr_nx;
    logic [NCH-1:0]   ctrl_wr, period_wr, tick, hit;

`ifdef TIMER_PRESCALER_EN
    logic [1:0]       psel      [NCH];
    logic [1:0]       psel_nx   [NCH];
    logic [5:0]       pre       [NCH];
    logic [5:0]       pre_nx    [NCH];

    function automatic logic [5:0] pre_limit(input logic [1:0] sel);
        case (sel)
            2'd0:    return 6'd0;
            2'd1:    return 6'd3;
            2'd2:    return 6'd15;
            default: return 6'd63;
        endcase
    endfunction
`endif

    always_comb begin
        ctrl_wr   = '0;
        period_wr = '0;
        tick      = '0;
        hit       = '0;
        per_nx    = per;
        pint_nx   = pint;
        ovr_nx    = ovr;
        for (int i = 0; i < NCH; i++) begin
            state_nx[i]  = state[i];
            period_nx[i] = period[i];
            cnt_nx[i]    = cnt[i];
`ifdef TIMER_PRESCALER_EN
            psel_nx[i]   = psel[i];
            pre_nx[i]    = pre[i];
`endif
            ctrl_wr[i]   = wr_en && (wr_ch == 3'(i)) && wr_reg;
            period_wr[i] = wr_en && (wr_ch == 3'(i)) && !wr_reg;

            // A CTRL write on this edge overrides any tick the channel would have taken.
`ifdef TIMER_PRESCALER_EN
            if (state[i] == RUN && !ctrl_wr[i]) begin
                tick[i]   = (pre[i] == pre_limit(psel[i]));
                pre_nx[i] = tick[i] ? 6'd0 : pre[i] + 6'd1;
            end
`else
            tick[i] = (state[i] == RUN) && !ctrl_wr[i];
`endif
            hit[i] = tick[i] && (cnt[i] == '0);
            if (tick[i] && !hit[i])
                cnt_nx[i] = cnt[i] - WIDTH'(1);

            if (int_ack[i]) begin
                pint_nx[i] = 1'b0;
                ovr_nx[i]  = 1'b0;
            end
            if (hit[i]) begin
                pint_nx[i] = 1'b1;
                if (pint[i])
                    ovr_nx[i] = 1'b1;
                if (per[i])
                    cnt_nx[i] = period[i];
                else
                    state_nx[i] = IDLE;
            end

            if (period_wr[i])
                period_nx[i] = wr_data;
            if (ctrl_wr[i]) begin
                state_nx[i] = wr_data[0] ? RUN : IDLE;
                per_nx[i]   = wr_data[1];
`ifdef TIMER_PRESCALER_EN
                psel_nx[i]  = wr_data[3:2];
`endif
                if (wr_data[0]) begin
                    cnt_nx[i] = period[i];
`ifdef TIMER_PRESCALER_EN
                    pre_nx[i] = 6'd0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per  <= '0;
            pint <= '0;
            ovr  <= '0;
            for (int i = 0; i < NCH; i++) begin
                state[i]  <= IDLE;
                period[i] <= '0;
                cnt[i]    <= '0;
`ifdef TIMER_PRESCALER_EN
                psel[i]   <= 2'd0;
                pre[i]    <= 6'd0;
`endif
            end
        end else begin
            per  <= per_nx;
            pint <= pint_nx;
            ovr  <= ovr_nx;
            for (int i = 0; i < NCH; i++) begin
                state[i]  <= state_nx[i];
                period[i] <= period_nx[i];
                cnt[i]    <= cnt_nx[i];
`ifdef TIMER_PRESCALER_EN
                psel[i]   <= psel_nx[i];
                pre[i]    <= pre_nx[i];
`endif
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_count
        assign count[g*WIDTH +: WIDTH] = cnt[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_multi.sv
`default_nettype none
// tb_timer_multi: directed scenarios plus randomized traffic checked against a cycle-level reference model.
module tb_timer_multi;
    localparam int NCH   = 4;
    localparam int WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 wr_en = 1'b0;
    logic [2:0]           wr_ch = '0;
    logic                 wr_reg = 1'b0;
    logic [WIDTH-1:0]     wr_data = '0;
    logic [NCH-1:0]       int_ack = '0;
    logic [NCH-1:0]       pint;
    logic [NCH-1:0]       ovr;
    logic [NCH*WIDTH-1:0] count;

    int n_cmp = 0;
    int n_err = 0;

    int m_period [NCH];
    int m_cnt    [NCH];
    int m_div    [NCH];
    int m_pre    [NCH];
    bit m_en     [NCH];
    bit m_per    [NCH];
    bit m_pint   [NCH];
    bit m_ovr    [NCH];

    timer_multi #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_reg  (wr_reg),
        .wr_data (wr_data),
        .int_ack (int_ack),
        .pint    (pint),
        .ovr     (ovr),
        .count   (count)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] cnt_of(input int ch);
        return count[ch*WIDTH +: WIDTH];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_period[c] = 0; m_cnt[c] = 0; m_div[c] = 1; m_pre[c] = 0;
            m_en[c] = 0; m_per[c] = 0; m_pint[c] = 0; m_ovr[c] = 0;
        end
    endtask

    // One clock edge of the reference: ticks are the cycles where the divider count wraps to zero.
    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit sel        = wr_en && (int'(wr_ch) == c);
            int old_period = m_period[c];
            bit prev_pint  = m_pint[c];
            bit ev         = 0;
            if (sel && wr_reg) begin
                m_en[c]  = wr_data[0];
                m_per[c] = wr_data[1];
`ifdef TIMER_PRESCALER_EN
                m_div[c] = 1 << (2 * int'(wr_data[3:2]));
`endif
                if (wr_data[0]) begin
                    m_cnt[c] = old_period;
                    m_pre[c] = 0;
                end
            end else if (m_en[c]) begin
                m_pre[c] = (m_pre[c] + 1) % m_div[c];
                if (m_pre[c] == 0) begin
                    if (m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
                    else ev = 1;
                end
            end
            if (sel && !wr_reg) m_period[c] = int'(wr_data);
            if (int_ack[c]) begin
                m_pint[c] = 0;
                m_ovr[c]  = 0;
            end
            if (ev) begin
                if (prev_pint) m_ovr[c] = 1;
                m_pint[c] = 1;
                if (m_per[c]) m_cnt[c] = old_period;
                else m_en[c] = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        #1;
    endtask

    task automatic wr(input int ch, input bit rg, input int data);
        wr_en   = 1'b1;
        wr_ch   = 3'(ch);
        wr_reg  = rg;
        wr_data = WIDTH'(data);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pint !== '0)  begin n_err++; $display("FAIL reset_pint got=%h exp=0", pint); end
        n_cmp++; if (ovr !== '0)   begin n_err++; $display("FAIL reset_ovr got=%h exp=0", ovr); end
        n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count got=%h exp=0", count); end
        reset = 1'b1;
        repeat (3) step();
        n_cmp++; if (pint !== '0 || count !== '0)
            begin n_err++; $display("FAIL reset_idle got pint=%h count=%h exp=0", pint, count); end
    endtask

    task automatic test_periodic();
        wr(0, 0, 5);
        wr(0, 1, 3);
        n_cmp++; if (cnt_of(0) !== 8'd5) begin n_err++; $display("FAIL per_load got=%0d exp=5", cnt_of(0)); end
        for (int k = 1; k <= 12; k++) begin
            int_ack = (k == 7) ? 4'b0001 : 4'b0000;
            step();
            int_ack = '0;
            n_cmp++; if (int'(cnt_of(0)) !== 5 - (k % 6))
                begin n_err++; $display("FAIL per_count k=%0d got=%0d exp=%0d", k, cnt_of(0), 5 - (k % 6)); end
            n_cmp++; if (pint[0] !== (k == 6 || k == 12))
                begin n_err++; $display("FAIL per_pint k=%0d got=%b exp=%b", k, pint[0], (k == 6 || k == 12)); end
            n_cmp++; if (ovr[0] !== 1'b0)
                begin n_err++; $display("FAIL per_ovr k=%0d got=%b exp=0", k, ovr[0]); end
        end
        wr(0, 1, 0);
        int_ack = 4'b0001; step(); int_ack = '0;
    endtask

    task automatic test_oneshot();
        wr(1, 0, 3);
        wr(1, 1, 1);
        for (int k = 1; k <= 24; k++) begin
            int exp_c = (k < 3) ? 3 - k : 0;
            step();
            n_cmp++; if (int'(cnt_of(1)) !== exp_c)
                begin n_err++; $display("FAIL one_count k=%0d got=%0d exp=%0d", k, cnt_of(1), exp_c); end
            n_cmp++; if (pint[1] !== (k >= 4) || ovr[1] !== 1'b0)
                begin n_err++; $display("FAIL one_pint k=%0d got=%b/%b exp=%b/0", k, pint[1], ovr[1], (k >= 4)); end
        end
        int_ack = 4'b0010; step(); int_ack = '0;
    endtask

    task automatic test_overrun_ack();
        bit exp_p [1:8] = '{0, 1, 1, 1, 1, 1, 0, 1};
        bit exp_o [1:8] = '{0, 0, 0, 1, 1, 1, 0, 0};
        wr(2, 0, 1);
        wr(2, 1, 3);
        for (int k = 1; k <= 8; k++) begin
            int_ack = (k >= 6) ? 4'b0100 : 4'b0000;
            step();
            int_ack = '0;
            n_cmp++; if (pint[2] !== exp_p[k])
                begin n_err++; $display("FAIL ovr_pint k=%0d got=%b exp=%b", k, pint[2], exp_p[k]); end
            n_cmp++; if (ovr[2] !== exp_o[k])
                begin n_err++; $display("FAIL ovr_flag k=%0d got=%b exp=%b", k, ovr[2], exp_o[k]); end
        end
        wr(2, 1, 0);
        int_ack = 4'b0100; step(); int_ack = '0;
    endtask

    task automatic test_midrun();
        wr(3, 0, 10);
        wr(3, 1, 3);
        for (int k = 1; k <= 17; k++) begin
            int exp_c = (k <= 10) ? 10 - k : 2 - ((k - 11) % 3);
            bit exp_p = (k >= 11) && !(k == 12 || k == 13);
            int_ack = (k == 12) ? 4'b1000 : 4'b0000;
            if (k == 4) wr(3, 0, 2);
            else step();
            int_ack = '0;
            n_cmp++; if (int'(cnt_of(3)) !== exp_c)
                begin n_err++; $display("FAIL mid_count k=%0d got=%0d exp=%0d", k, cnt_of(3), exp_c); end
            n_cmp++; if (pint[3] !== exp_p || ovr[3] !== (k >= 17))
                begin n_err++; $display("FAIL mid_pint k=%0d got=%b/%b exp=%b/%b", k, pint[3], ovr[3], exp_p, (k >= 17)); end
        end
        wr(3, 1, 0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            n_cmp++; if (cnt_of(3) !== 8'd2 || pint[3] !== 1'b1 || ovr[3] !== 1'b1)
                begin n_err++; $display("FAIL mid_freeze got=%0d/%b/%b exp=2/1/1", cnt_of(3), pint[3], ovr[3]); end
        end
        wr(3, 1, 3);
        step();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (pint !== '0 || ovr !== '0 || count !== '0)
            begin n_err++; $display("FAIL async_reset got=%h/%h/%h exp=0", pint, ovr, count); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) step();
        n_cmp++; if (pint !== '0 || count !== '0)
            begin n_err++; $display("FAIL post_reset got=%h/%h exp=0", pint, count); end
    endtask

    task automatic test_invalid_ch();
        wr(5, 0, 0);
        wr(5, 1, 3);
        wr(4, 1, 3);
        wr(7, 1, 3);
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++; if (pint !== '0 || count !== '0)
                begin n_err++; $display("FAIL invalid_ch k=%0d got=%h/%h exp=0", k, pint, count); end
        end
    endtask

    task automatic test_prescale();
`ifdef TIMER_PRESCALER_EN
        int exp_k = 12;
`else
        int exp_k = 3;
`endif
        wr(0, 0, 2);
        wr(0, 1, 7);
        for (int k = 1; k <= exp_k; k++) begin
            step();
            n_cmp++; if (pint[0] !== (k == exp_k))
                begin n_err++; $display("FAIL presc_pint k=%0d got=%b exp=%b", k, pint[0], (k == exp_k)); end
        end
        wr(0, 1, 0);
        int_ack = 4'b0001; step(); int_ack = '0;
    endtask

    task automatic test_random();
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int n = 0; n < 500; n++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = 3'($urandom_range(0, 5));
            wr_reg  = 1'($urandom_range(0, 1));
            wr_data = wr_reg ? WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom_range(0, 6));
            int_ack = ($urandom_range(0, 4) == 0) ? NCH'($urandom) : '0;
            step();
            for (int c = 0; c < NCH; c++) begin
                n_cmp++; if (int'(cnt_of(c)) !== m_cnt[c])
                    begin n_err++; $display("FAIL rnd_count n=%0d ch=%0d got=%0d exp=%0d", n, c, cnt_of(c), m_cnt[c]); end
                n_cmp++; if (pint[c] !== m_pint[c])
                    begin n_err++; $display("FAIL rnd_pint n=%0d ch=%0d got=%b exp=%b", n, c, pint[c], m_pint[c]); end
                n_cmp++; if (ovr[c] !== m_ovr[c])
                    begin n_err++; $display("FAIL rnd_ovr n=%0d ch=%0d got=%b exp=%b", n, c, ovr[c], m_ovr[c]); end
            end
        end
        wr_en   = 1'b0;
        int_ack = '0;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_overrun_ack();
        test_midrun();
        test_invalid_ch();
        test_prescale();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
